seg_display_arbiter: RTL and testbench
======================================

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100000: minimum cycles a granted value stays on the display; legal range >= 2.
REQ-002 SHALL have parameter BLINK_HALF, default 25000: blink half-period in cycles; used only when SEG_ARB_BLINK_EN is defined; legal range >= 1.
REQ-003 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port a_valid, input, 1: requester A has a display value.
REQ-006 SHALL have port a_data, input, 32: requester A value; 8 hex nibbles, bits [3:0] are digit 0.
REQ-007 SHALL have port a_ready, output, 1: requester A value accepted this cycle.
REQ-008 SHALL have port b_valid, b_data, b_ready, with the same directions, widths and meanings as A.
REQ-009 SHALL have port disp_data, output, 32: registered value fed to the 8-digit multiplexed display driver.
REQ-010 SHALL have port disp_blank, output, 1: request to blank all digits.
REQ-011 SHALL have port owner, output, 1: requester whose value is shown; 0=A, 1=B.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, GRANT, HOLD.
REQ-014 In IDLE, if a_valid or b_valid is high, the block SHALL select a requester and enter GRANT on the next cycle. If neither is high, it SHALL stay in IDLE.
REQ-015 Selection SHALL be round-robin:
- Only one requester valid: that requester wins.
- Both valid: the requester not granted last wins.
REQ-016 In GRANT, the block SHALL assert the winner's ready as a registered output for exactly one cycle. The other ready SHALL stay low.
REQ-017 A transfer SHALL occur when ready and valid are both high in the same cycle.
- On transfer, disp_data SHALL take that requester's data on the following cycle.
- On transfer, owner SHALL update on the same edge as disp_data.
- On transfer, the last-grant pointer SHALL update on the same edge.
REQ-018 If the winner's valid is low during GRANT, no transfer SHALL occur. disp_data, owner and the pointer SHALL be unchanged, and the FSM SHALL return to IDLE.
REQ-019 After a transfer the FSM SHALL enter HOLD and remain there exactly HOLD_CYCLES cycles, then return to IDLE. New requests SHALL be ignored during HOLD.
REQ-020 The hold counter SHALL use $clog2(HOLD_CYCLES+1) bits, count up from 0, and clear on entry to HOLD.
REQ-021 disp_data SHALL change only on a transfer edge or on reset; it SHALL be stable during IDLE and HOLD.
REQ-022 Latency: with valid high in IDLE at cycle N, ready SHALL be high at N+1 and the new disp_data SHALL be visible at N+2.
REQ-023 The ready outputs SHALL never both be high in the same cycle.

Reset
REQ-024 When reset is high at a rising edge, the block SHALL set:
- state = IDLE
- disp_data = 0
- disp_blank = 0
- owner = 0
- a_ready = b_ready = 0
- busy = 0
- hold counter = 0
- last-grant pointer = B, so A wins the first contention.
REQ-025 Reset SHALL take priority over all other activity, including an in-progress GRANT or HOLD.
REQ-026 A handshake coinciding with reset SHALL be discarded.

Configuration
REQ-027 Macro SEG_ARB_BLINK_EN SHALL be the only build option.
REQ-028 With SEG_ARB_BLINK_EN defined:
- During HOLD, disp_blank SHALL toggle every BLINK_HALF cycles.
- disp_blank SHALL start at 0 on entry to HOLD, using a dedicated counter.
- disp_blank SHALL be forced to 0 in IDLE and GRANT.
REQ-029 With SEG_ARB_BLINK_EN undefined:
- disp_blank SHALL be constant 0.
- No blink counter logic SHALL be synthesized.

Verification (HOLD_CYCLES=4, BLINK_HALF=2)
REQ-030 Reset release, no valids -> disp_data=0, owner=0, busy=0 and both readies 0 for 20 cycles.
REQ-031 a_valid=1 with a_data=32'h12345678 at cycle N -> a_ready=1 at N+1 only; disp_data=32'h12345678 and owner=0 at N+2; busy low again after 4 HOLD cycles.
REQ-032 Both valid from reset, a_data=32'hAAAA0001, b_data=32'hBBBB0002, held continuously -> grants alternate A, B, A; disp_data alternates accordingly; ready pulses are never simultaneous.
REQ-033 b_valid pulsed high during HOLD, then low before IDLE -> no b_ready and disp_data unchanged.
REQ-034 Reset asserted mid-HOLD after showing 32'hDEADBEEF -> next cycle disp_data=0, state IDLE; then a single A request is granted normally.
REQ-035 With SEG_ARB_BLINK_EN defined, one transfer -> disp_blank reads 0,0,1,1 across the 4 HOLD cycles; disp_blank is 0 in IDLE. Without the macro, disp_blank stays 0.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter granting one of two requesters ownership of an 8-digit display.
// Build option: SEG_ARB_BLINK_EN enables blinking (disp_blank toggling) during HOLD.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 100000,
  parameter int BLINK_HALF  = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [31:0] disp_data,
  output logic        disp_blank,
  output logic        owner,
  output logic        busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  generate
    if (HOLD_CYCLES < 2 || BLINK_HALF < 1) begin : g_param_check
      $error("seg_display_arbiter: HOLD_CYCLES must be >= 2 and BLINK_HALF >= 1");
    end
  endgenerate

  state_t             r_state;
  state_t             w_next;
  logic               r_last;
  logic               w_sel;
  logic               w_xfer;
  logic               w_hold_done;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic               r_a_ready;
  logic               r_b_ready;
  logic               r_owner;
  logic               r_busy;
  logic [31:0]        r_disp;

  // 0 selects A, 1 selects B; on contention the requester not granted last wins
  assign w_sel       = (a_valid && b_valid) ? ~r_last : ~a_valid;
  assign w_xfer      = (r_state == GRANT) && ((r_a_ready && a_valid) || (r_b_ready && b_valid));
  assign w_hold_done = (r_hold_cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (a_valid || b_valid) ? GRANT : IDLE;
      GRANT:   w_next = w_xfer ? HOLD : IDLE;
      HOLD:    w_next = w_hold_done ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_ready  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_busy     <= 1'b0;
      r_disp     <= 32'd0;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
    end else begin
      r_a_ready <= (r_state == IDLE) && (w_next == GRANT) && !w_sel;
      r_b_ready <= (r_state == IDLE) && (w_next == GRANT) && w_sel;
      r_busy    <= (w_next != IDLE);
      if (w_xfer) begin
        r_disp  <= r_b_ready ? b_data : a_data;
        r_owner <= r_b_ready;
        r_last  <= r_b_ready;
      end
      // Counter sits at 0 outside HOLD, so it is already clear on entry
      if (r_state == HOLD && !w_hold_done) begin
        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

`ifdef SEG_ARB_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_blank;

  // Blink phase restarts at 0 every HOLD entry and is forced low outside HOLD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk_cnt <= '0;
      r_blank   <= 1'b0;
    end else if (r_state == HOLD && w_next == HOLD) begin
      if (r_blk_cnt == BLK_W'(BLINK_HALF - 1)) begin
        r_blk_cnt <= '0;
        r_blank   <= ~r_blank;
      end else begin
        r_blk_cnt <= r_blk_cnt + BLK_W'(1);
      end
    end else begin
      r_blk_cnt <= '0;
      r_blank   <= 1'b0;
    end
  end

  assign disp_blank = r_blank;
`else
  assign disp_blank = 1'b0;
`endif

  assign a_ready   = r_a_ready;
  assign b_ready   = r_b_ready;
  assign disp_data = r_disp;
  assign owner     = r_owner;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (HOLD_CYCLES=4, BLINK_HALF=2).
module tb_seg_display_arbiter;

  localparam int HC = 4;
  localparam int BH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic [31:0] a_data = 32'd0;
  logic [31:0] b_data = 32'd0;
  logic        a_ready;
  logic        b_ready;
  logic [31:0] disp_data;
  logic        disp_blank;
  logic        owner;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        own;
  } exp_t;

  typedef struct {
    logic        av;
    logic        bv;
    logic [31:0] ad;
    logic [31:0] bd;
    logic        own;
    logic [31:0] data;
    logic        pulse_b;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  seg_display_arbiter #(.HOLD_CYCLES(HC), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .disp_data(disp_data), .disp_blank(disp_blank), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic exp_blank(input int h);
`ifdef SEG_ARB_BLINK_EN
    return ((h / BH) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] prev_disp = 32'd0;
  bit          rst_flag = 1'b1;

  // Scoreboard: every change of disp_data must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    chk("ready_mutex", {31'd0, a_ready & b_ready}, 32'd0);
    if (reset) begin
      rst_flag = 1'b1;
    end else if (rst_flag) begin
      rst_flag  = 1'b0;
      prev_disp = disp_data;
    end else if (disp_data !== prev_disp) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_change", disp_data, prev_disp);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", disp_data, e.data);
        chk("sb_owner", {31'd0, owner}, {31'd0, e.own});
      end
      prev_disp = disp_data;
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    a_valid = v.av; b_valid = v.bv; a_data = v.ad; b_data = v.bd;
    sb_q.push_back('{data: v.data, own: v.own});
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("grant_a_ready", {31'd0, a_ready}, {31'd0, ~v.own});
    chk("grant_b_ready", {31'd0, b_ready}, {31'd0, v.own});
    chk("grant_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    for (int h = 0; h < HC; h++) begin
      @(negedge clk);
      chk("hold_disp", disp_data, v.data);
      chk("hold_owner", {31'd0, owner}, {31'd0, v.own});
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_readies", {30'd0, a_ready, b_ready}, 32'd0);
      chk("hold_blank", {31'd0, disp_blank}, {31'd0, exp_blank(h)});
      if (v.pulse_b && h == 0) begin
        b_data = 32'hFFFF0000; b_valid = 1'b1;
      end
      if (h == 2) b_valid = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_idle_busy", {31'd0, busy}, 32'd0);
      chk("post_idle_readies", {30'd0, a_ready, b_ready}, 32'd0);
      chk("post_idle_blank", {31'd0, disp_blank}, 32'd0);
      chk("post_idle_disp", disp_data, v.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int cyc;

    vecs[0] = '{1'b1, 1'b0, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h00000000, 32'h0000BEEF, 1'b1, 32'h0000BEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 32'hAAAA0001, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h11110000, 32'h22220000, 1'b1, 32'h22220000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h33330000, 32'h44440000, 1'b0, 32'h33330000, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h00000000, 32'h55550000, 1'b1, 32'h55550000, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h00000000, 32'h66660000, 1'b1, 32'h66660000, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h77770000, 32'h00000000, 1'b0, 32'h77770000, 1'b0};

    do_reset(3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_disp", disp_data, 32'd0);
      chk("rst_owner", {31'd0, owner}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_readies", {30'd0, a_ready, b_ready}, 32'd0);
      chk("rst_blank", {31'd0, disp_blank}, 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // B granted but withdraws before the handshake: pointer must stay on A
    @(posedge clk); #1;
    b_valid = 1'b1; b_data = 32'hABCD0000;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("nogo_b_ready", {31'd0, b_ready}, 32'd1);
    chk("nogo_a_ready", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    chk("nogo_busy", {31'd0, busy}, 32'd0);
    chk("nogo_disp", disp_data, 32'h77770000);
    chk("nogo_owner", {31'd0, owner}, 32'd0);
    run_vec('{1'b1, 1'b1, 32'h88880000, 32'h99990000, 1'b1, 32'h99990000, 1'b0});

    // Continuous contention from reset: A, B, A
    do_reset(2);
    a_valid = 1'b1; b_valid = 1'b1; a_data = 32'hAAAA0001; b_data = 32'hBBBB0002;
    sb_q.push_back('{data: 32'hAAAA0001, own: 1'b0});
    sb_q.push_back('{data: 32'hBBBB0002, own: 1'b1});
    sb_q.push_back('{data: 32'hAAAA0001, own: 1'b0});
    cyc = 0;
    while (order.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (a_ready) order.push_back(0);
      else if (b_ready) order.push_back(1);
    end
    chk("rr_grant_count", 32'(order.size()), 32'd3);
    for (int i = 0; i < order.size(); i++) begin
      chk("rr_order", 32'(order[i]), 32'(i % 2));
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rr_end_busy", {31'd0, busy}, 32'd0);
    chk("rr_end_disp", disp_data, 32'hAAAA0001);

    // Reset in the middle of HOLD
    @(posedge clk); #1;
    a_valid = 1'b1; a_data = 32'hDEADBEEF;
    sb_q.push_back('{data: 32'hDEADBEEF, own: 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_disp", disp_data, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_owner", {31'd0, owner}, 32'd0);
    chk("midrst_readies", {30'd0, a_ready, b_ready}, 32'd0);
    run_vec('{1'b1, 1'b0, 32'h0000CAFE, 32'h00000000, 1'b0, 32'h0000CAFE, 1'b0});

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
